// File: rtl/fir_pkg.sv
// fir_pkg: shared defaults and the width helper for the FIR decimator chain
package fir_pkg;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int DECIM_DEF = 4;
    localparam int FIFO_DEPTH_DEF = 8;
    function automatic int log2_ceil(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/fir_sync_fifo.sv
// fir_sync_fifo: synchronous FIFO; full/empty come from level, and a pop frees room for a same-cycle push
module fir_sync_fifo
    import fir_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF,
    localparam int AW = log2_ceil(DEPTH),
    localparam int LW = log2_ceil(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0] level_q, level_d;
    logic push_ok, pop_ok;
    assign full = level_q == LW'(DEPTH);
    assign empty = level_q == '0;
    assign level = level_q;
    assign pop_data = empty ? '0 : mem_q[rd_q];
    // next-state: pointers wrap naturally because DEPTH is a power of two
    always_comb begin
        pop_ok = pop && !empty;
        push_ok = push && (!full || pop_ok);
        mem_d = mem_q;
        if (push_ok) mem_d[wr_q] = push_data;
        wr_d = push_ok ? wr_q + 1'b1 : wr_q;
        rd_d = pop_ok ? rd_q + 1'b1 : rd_q;
        level_d = (push_ok && !pop_ok) ? level_q + 1'b1 : (!push_ok && pop_ok) ? level_q - 1'b1 : level_q;
    end
    // state registers; storage is not reset since pop_data is masked while empty
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            level_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            level_q <= level_d;
        end
        mem_q <= mem_d;
    end
endmodule

// File: rtl/fir_decim_avg.sv
// fir_decim_avg: averages each group of DECIM samples into an output FIFO; define FIR_DECIM_ROUND_EN for round-half-up instead of truncation
module fir_decim_avg
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DECIM = DECIM_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    localparam int LW = log2_ceil(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    input  logic                  data_out_ready,
    output logic [LW-1:0]         level,
    output logic                  overflow
);
    localparam int PW = log2_ceil(DECIM);
    localparam int AW = DATA_WIDTH + PW;
    logic [PW-1:0] phase_q, phase_d;
    logic [AW-1:0] acc_q, acc_d, sum, rnd;
    logic [DATA_WIDTH-1:0] result;
    logic push, pop, full, empty, overflow_q, overflow_d;
    assign data_out_valid = !empty;
    assign overflow = overflow_q;
    // group accumulation, averaging and drop detection
    always_comb begin
        sum = acc_q + AW'(data_in);
`ifdef FIR_DECIM_ROUND_EN
        rnd = sum + AW'(DECIM / 2);
`else
        rnd = sum;
`endif
        result = DATA_WIDTH'(rnd >> PW);
        push = data_in_valid && phase_q == PW'(DECIM - 1);
        pop = data_out_valid && data_out_ready;
        phase_d = data_in_valid ? phase_q + 1'b1 : phase_q;
        acc_d = !data_in_valid ? acc_q : (phase_q == '0 ? AW'(data_in) : sum);
        overflow_d = overflow_q || (push && full && !pop);
    end
    // phase, accumulator and sticky overflow registers
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
            acc_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            acc_q <= acc_d;
            overflow_q <= overflow_d;
        end
    end
    fir_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .push_data(result),
        .pop(pop),
        .pop_data(data_out),
        .level(level),
        .full(full),
        .empty(empty)
    );
endmodule
